// File: rtl/alarm_sequencer_if.sv
// Signal bundle between the alarm sequencer, the timekeeping counters,
// the user buttons and the blink/beep output stage.
interface alarm_sequencer_if;
  logic       alarm_en;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [4:0] alm_hour;
  logic [5:0] alm_min;
  logic       snooze_btn;
  logic       stop_btn;
  logic       ring_on;
  logic [1:0] state;
  logic [2:0] snooze_cnt;
  logic       ring_missed;

  modport slave (
    input  alarm_en, cur_hour, cur_min, cur_sec, alm_hour, alm_min,
           snooze_btn, stop_btn,
    output ring_on, state, snooze_cnt, ring_missed
  );

  modport master (
    output alarm_en, cur_hour, cur_min, cur_sec, alm_hour, alm_min,
           snooze_btn, stop_btn,
    input  ring_on, state, snooze_cnt, ring_missed
  );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze/timeout sequencer running at 1 kHz (one cycle = 1 ms).
// Fires on an hh:mm:00 match and drives the blink generator's `on` input.
module alarm_sequencer #(
  parameter int unsigned RING_TIMEOUT_MS = 60000,
  parameter int unsigned SNOOZE_MS       = 300000,
  parameter int unsigned MAX_SNOOZE      = 3
) (
  input  logic              clk1khz,
  input  logic              rst,
  alarm_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_RINGING = 2'b10,
    S_SNOOZE  = 2'b11
  } state_e;

  localparam logic [31:0] RING_LAST = 32'(RING_TIMEOUT_MS - 1);
  localparam logic [31:0] SNZ_LAST  = 32'(SNOOZE_MS - 1);
  localparam logic [2:0]  SNZ_MAX   = 3'(MAX_SNOOZE);

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [2:0]  snooze_cnt_q, snooze_cnt_d;
  logic        ring_missed_q, ring_missed_d;
  logic        ring_on_q;
  logic        fired_q, fired_d;
  logic        stop_prev_q, snooze_prev_q;

  logic match, stop_press, snooze_press;

  assign match = (bus.cur_hour == bus.alm_hour) && (bus.cur_min == bus.alm_min) &&
                 (bus.cur_sec == 6'd0);
  // Stop dominates a simultaneous snooze press.
  assign stop_press   = bus.stop_btn & ~stop_prev_q;
  assign snooze_press = bus.snooze_btn & ~snooze_prev_q & ~stop_press;

  always_comb begin
    state_d       = state_q;
    snooze_cnt_d  = snooze_cnt_q;
    ring_missed_d = ring_missed_q;
    if (stop_press) ring_missed_d = 1'b0;

    if (!bus.alarm_en) begin
      state_d       = S_IDLE;
      snooze_cnt_d  = 3'd0;
      ring_missed_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_ARMED;
        S_ARMED: if (match && !fired_q) state_d = S_RINGING;
        S_RINGING: begin
          if (stop_press) begin
            state_d      = S_ARMED;
            snooze_cnt_d = 3'd0;
          end else if (snooze_press && (snooze_cnt_q < SNZ_MAX)) begin
            state_d      = S_SNOOZE;
            snooze_cnt_d = snooze_cnt_q + 3'd1;
          end else if (timer_q == RING_LAST) begin
            state_d       = S_ARMED;
            snooze_cnt_d  = 3'd0;
            ring_missed_d = 1'b1;
          end
        end
        S_SNOOZE: begin
          if (stop_press) begin
            state_d      = S_ARMED;
            snooze_cnt_d = 3'd0;
          end else if (timer_q == SNZ_LAST) begin
            state_d = S_RINGING;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    timer_d = timer_q;
    if (state_d != state_q)
      timer_d = 32'd0;
    else if (state_q == S_RINGING || state_q == S_SNOOZE)
      timer_d = timer_q + 32'd1;

    // fired blocks re-triggering for the rest of the second in which cur_sec stays 0.
    fired_d = fired_q & match;
    if (state_d == S_RINGING && state_q != S_RINGING) fired_d = 1'b1;
  end

  always_ff @(posedge clk1khz) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= 32'd0;
      snooze_cnt_q  <= 3'd0;
      ring_missed_q <= 1'b0;
      ring_on_q     <= 1'b0;
      fired_q       <= 1'b0;
      stop_prev_q   <= 1'b0;
      snooze_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      snooze_cnt_q  <= snooze_cnt_d;
      ring_missed_q <= ring_missed_d;
      ring_on_q     <= (state_d == S_RINGING);
      fired_q       <= fired_d;
      stop_prev_q   <= bus.stop_btn;
      snooze_prev_q <= bus.snooze_btn;
    end
  end

  assign bus.ring_on     = ring_on_q;
  assign bus.state       = state_q;
  assign bus.snooze_cnt  = snooze_cnt_q;
  assign bus.ring_missed = ring_missed_q;
endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer with short timeouts (ring 10, snooze 5, max 2).
module tb_alarm_sequencer;
  localparam int RT = 10;
  localparam int SN = 5;
  localparam int MS = 2;
  localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, RING = 2'd2, SNZ = 2'd3;

  logic clk1khz = 1'b0;
  logic rst     = 1'b1;
  alarm_sequencer_if bus();

  alarm_sequencer #(.RING_TIMEOUT_MS(RT), .SNOOZE_MS(SN), .MAX_SNOOZE(MS)) dut (
    .clk1khz (clk1khz),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk1khz = ~clk1khz;

  typedef struct packed {
    logic [1:0] st;
    logic       ro;
    logic [2:0] sc;
    logic       rm;
  } exp_t;

  exp_t sb[$];
  exp_t obs_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t ex(input logic [1:0] st, input logic [2:0] sc, input logic rm);
    exp_t e;
    e.st = st;
    e.ro = (st == RING);
    e.sc = sc;
    e.rm = rm;
    return e;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, record what the DUT shows after the edge.
  task automatic apply(input logic r, input logic en, input logic snz, input logic stp,
                       input logic [5:0] sec, input exp_t e);
    exp_t o;
    rst = r;
    bus.alarm_en   = en;
    bus.snooze_btn = snz;
    bus.stop_btn   = stp;
    bus.cur_sec    = sec;
    sb.push_back(e);
    @(posedge clk1khz);
    #1;
    o.st = bus.state;
    o.ro = bus.ring_on;
    o.sc = bus.snooze_cnt;
    o.rm = bus.ring_missed;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    exp_t e, o;
    int k = 0;
    apply(1, 0, 0, 0, 1, ex(IDLE, 0, 0));
    apply(1, 1, 0, 0, 1, ex(IDLE, 0, 0));
    apply(0, 0, 0, 0, 1, ex(IDLE, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset #%0d: got st=%0d ro=%0b sc=%0d rm=%0b, expected st=%0d ro=%0b sc=%0d rm=%0b",
                 k, o.st, o.ro, o.sc, o.rm, e.st, e.ro, e.sc, e.rm);
      end
      k++;
    end
  endtask

  task automatic test_ring_match();
    exp_t e, o;
    int k = 0;
    apply(0, 1, 0, 0, 1,  ex(ARMED, 0, 0));
    apply(0, 1, 0, 0, 59, ex(ARMED, 0, 0));
    apply(0, 1, 0, 0, 0,  ex(RING, 0, 0));
    apply(0, 1, 0, 1, 0,  ex(ARMED, 0, 0));
    for (int i = 0; i < 990; i++) apply(0, 1, 0, 0, 0, ex(ARMED, 0, 0));
    apply(0, 1, 0, 0, 1, ex(ARMED, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL ring_match #%0d: got st=%0d ro=%0b sc=%0d rm=%0b, expected st=%0d ro=%0b sc=%0d rm=%0b",
                 k, o.st, o.ro, o.sc, o.rm, e.st, e.ro, e.sc, e.rm);
      end
      k++;
    end
  endtask

  task automatic test_snooze();
    exp_t e, o;
    int k = 0;
    apply(0, 1, 0, 0, 0, ex(RING, 0, 0));
    apply(0, 1, 1, 0, 5, ex(SNZ, 1, 0));
    for (int i = 0; i < SN - 1; i++) apply(0, 1, 0, 0, 5, ex(SNZ, 1, 0));
    apply(0, 1, 0, 0, 5, ex(RING, 1, 0));
    apply(0, 1, 1, 0, 5, ex(SNZ, 2, 0));
    for (int i = 0; i < SN - 1; i++) apply(0, 1, 0, 0, 5, ex(SNZ, 2, 0));
    apply(0, 1, 0, 0, 5, ex(RING, 2, 0));
    apply(0, 1, 1, 0, 5, ex(RING, 2, 0));
    apply(0, 1, 0, 0, 5, ex(RING, 2, 0));
    apply(0, 1, 0, 1, 5, ex(ARMED, 0, 0));
    apply(0, 1, 0, 0, 5, ex(ARMED, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL snooze #%0d: got st=%0d ro=%0b sc=%0d rm=%0b, expected st=%0d ro=%0b sc=%0d rm=%0b",
                 k, o.st, o.ro, o.sc, o.rm, e.st, e.ro, e.sc, e.rm);
      end
      k++;
    end
  endtask

  task automatic test_timeout();
    exp_t e, o;
    int k = 0;
    apply(0, 1, 0, 0, 0, ex(RING, 0, 0));
    apply(0, 1, 1, 0, 1, ex(SNZ, 1, 0));
    for (int i = 0; i < SN - 1; i++) apply(0, 1, 0, 0, 1, ex(SNZ, 1, 0));
    apply(0, 1, 0, 0, 1, ex(RING, 1, 0));
    for (int i = 0; i < RT - 1; i++) apply(0, 1, 0, 0, 1, ex(RING, 1, 0));
    apply(0, 1, 0, 0, 1, ex(ARMED, 0, 1));
    apply(0, 1, 0, 0, 1, ex(ARMED, 0, 1));
    apply(0, 1, 0, 0, 1, ex(ARMED, 0, 1));
    apply(0, 1, 0, 1, 1, ex(ARMED, 0, 0));
    apply(0, 1, 0, 0, 1, ex(ARMED, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL timeout #%0d: got st=%0d ro=%0b sc=%0d rm=%0b, expected st=%0d ro=%0b sc=%0d rm=%0b",
                 k, o.st, o.ro, o.sc, o.rm, e.st, e.ro, e.sc, e.rm);
      end
      k++;
    end
  endtask

  task automatic test_stop_snooze_same();
    exp_t e, o;
    int k = 0;
    apply(0, 1, 0, 0, 0, ex(RING, 0, 0));
    apply(0, 1, 1, 0, 1, ex(SNZ, 1, 0));
    for (int i = 0; i < SN - 1; i++) apply(0, 1, 0, 0, 1, ex(SNZ, 1, 0));
    apply(0, 1, 0, 0, 1, ex(RING, 1, 0));
    apply(0, 1, 1, 1, 1, ex(ARMED, 0, 0));
    // stop stays held for 20 cycles in total, re-ringing part way through
    for (int i = 0; i < 12; i++) apply(0, 1, 0, 1, 1, ex(ARMED, 0, 0));
    apply(0, 1, 0, 1, 0, ex(RING, 0, 0));
    for (int i = 0; i < 6; i++) apply(0, 1, 0, 1, 1, ex(RING, 0, 0));
    apply(0, 1, 0, 0, 1, ex(RING, 0, 0));
    apply(0, 1, 0, 1, 1, ex(ARMED, 0, 0));
    apply(0, 1, 0, 0, 1, ex(ARMED, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL stop_snooze #%0d: got st=%0d ro=%0b sc=%0d rm=%0b, expected st=%0d ro=%0b sc=%0d rm=%0b",
                 k, o.st, o.ro, o.sc, o.rm, e.st, e.ro, e.sc, e.rm);
      end
      k++;
    end
  endtask

  task automatic test_disable();
    exp_t e, o;
    int k = 0;
    apply(0, 1, 0, 0, 0, ex(RING, 0, 0));
    apply(0, 1, 1, 0, 1, ex(SNZ, 1, 0));
    apply(0, 1, 0, 0, 1, ex(SNZ, 1, 0));
    apply(0, 0, 0, 0, 1, ex(IDLE, 0, 0));
    apply(0, 0, 0, 0, 1, ex(IDLE, 0, 0));
    apply(0, 1, 0, 0, 1, ex(ARMED, 0, 0));
    apply(0, 1, 0, 0, 1, ex(ARMED, 0, 0));
    apply(0, 1, 0, 0, 0, ex(RING, 0, 0));
    apply(0, 1, 0, 1, 1, ex(ARMED, 0, 0));
    apply(0, 1, 0, 0, 1, ex(ARMED, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL disable #%0d: got st=%0d ro=%0b sc=%0d rm=%0b, expected st=%0d ro=%0b sc=%0d rm=%0b",
                 k, o.st, o.ro, o.sc, o.rm, e.st, e.ro, e.sc, e.rm);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid_ring();
    exp_t e, o;
    int k = 0;
    apply(0, 1, 0, 0, 0, ex(RING, 0, 0));
    for (int i = 0; i < RT - 1; i++) apply(0, 1, 0, 0, 1, ex(RING, 0, 0));
    apply(0, 1, 0, 0, 1, ex(ARMED, 0, 1));
    apply(0, 1, 0, 0, 0, ex(RING, 0, 1));
    apply(0, 1, 0, 0, 1, ex(RING, 0, 1));
    apply(1, 1, 0, 0, 1, ex(IDLE, 0, 0));
    apply(0, 1, 0, 0, 1, ex(ARMED, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset_mid_ring #%0d: got st=%0d ro=%0b sc=%0d rm=%0b, expected st=%0d ro=%0b sc=%0d rm=%0b",
                 k, o.st, o.ro, o.sc, o.rm, e.st, e.ro, e.sc, e.rm);
      end
      k++;
    end
  endtask

  initial begin
    bus.alarm_en   = 1'b0;
    bus.cur_hour   = 5'd7;
    bus.cur_min    = 6'd30;
    bus.cur_sec    = 6'd1;
    bus.alm_hour   = 5'd7;
    bus.alm_min    = 6'd30;
    bus.snooze_btn = 1'b0;
    bus.stop_btn   = 1'b0;
    test_reset();
    test_ring_match();
    test_snooze();
    test_timeout();
    test_stop_snooze_same();
    test_disable();
    test_reset_mid_ring();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
